// File: rtl/m_exec_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : m_exec_pkg
//  Purpose  : Shared types and constants for the iterative RV32M unit.
//  Revision : 1.0  initial release
// ============================================================================
package m_exec_pkg;

   localparam int DEF_XLEN = 32;
   localparam int CNT_W    = $clog2(DEF_XLEN);

   localparam logic [DEF_XLEN-1:0] DIV_ZERO_Q = {DEF_XLEN{1'b1}};
   localparam logic [DEF_XLEN-1:0] SIGNED_MIN = {1'b1, {(DEF_XLEN-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PREP  = 3'd1,
      CALC  = 3'd2,
      FIXUP = 3'd3,
      DONE  = 3'd4
   } state_e;

endpackage
`default_nettype wire

// File: rtl/m_exec_if.sv
`default_nettype none
// ============================================================================
//  Module   : m_exec_if
//  Purpose  : Request/response bundle between the M decoder and m_exec_unit.
//  Revision : 1.0  initial release
// ============================================================================
interface m_exec_if
   import m_exec_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
);
   logic            start_i;
   logic            mult_on_i;
   logic            div_on_i;
   logic            signed_A_i;
   logic            signed_B_i;
   logic            upper_rem_i;
   logic [XLEN-1:0] op_a_i;
   logic [XLEN-1:0] op_b_i;
   logic            kill_i;
   logic            busy_o;
   logic            done_o;
   logic [XLEN-1:0] result_o;

   modport master (
      output start_i, mult_on_i, div_on_i, signed_A_i, signed_B_i,
             upper_rem_i, op_a_i, op_b_i, kill_i,
      input  busy_o, done_o, result_o
   );

   modport slave (
      input  start_i, mult_on_i, div_on_i, signed_A_i, signed_B_i,
             upper_rem_i, op_a_i, op_b_i, kill_i,
      output busy_o, done_o, result_o
   );
endinterface
`default_nettype wire

// File: rtl/m_abs_neg.sv
`default_nettype none
// ============================================================================
//  Module   : m_abs_neg
//  Purpose  : Conditional two's-complement negation (magnitude / sign fixup).
//  Revision : 1.0  initial release
// ============================================================================
module m_abs_neg #(
   parameter int WIDTH = 32
) (
   input  logic             i_neg,
   input  logic [WIDTH-1:0] i_val,
   output logic [WIDTH-1:0] o_val
);

   // Negate the input when requested, otherwise pass it through.
   always_comb begin
      o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;
   end

endmodule
`default_nettype wire

// File: rtl/m_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : m_exec_unit
//  Purpose  : Iterative RV32M multiply/divide unit. Shift-add multiply and
//             restoring divide, one bit per cycle, start/busy/done handshake.
//  Options  : M_EXEC_FAST_SPECIAL_EN - divide-by-zero and signed overflow
//             bypass the iteration and go straight to fixup.
//  Revision : 1.0  initial release
// ============================================================================
module m_exec_unit
   import m_exec_pkg::*;
#(
   parameter int XLEN = DEF_XLEN   // constants below are sized for RV32
) (
   input  wire logic clk_i,
   input  wire logic rst_n_i,
   m_exec_if.slave   bus
);

   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(XLEN - 1);

   state_e              r_state, w_next;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_mult, r_sa, r_sb, r_upper, r_neg;
   logic [XLEN-1:0]     r_a, r_b, r_mcand, r_result;
   logic [2*XLEN-1:0]   r_acc;

   logic                w_accept, w_sign_a, w_sign_b, w_div_zero, w_ovf;
   logic [XLEN-1:0]     w_abs_a, w_abs_b, w_sel, w_result;
   logic [XLEN:0]       w_mul_sum, w_div_trial;
   logic [2*XLEN-1:0]   w_mul_next, w_div_next, w_fix_in, w_fix_out;

   assign w_accept   = bus.start_i & (bus.mult_on_i | bus.div_on_i) & (r_state == IDLE);
   assign w_sign_a   = r_sa & r_a[XLEN-1];
   assign w_sign_b   = r_sb & r_b[XLEN-1];
   assign w_div_zero = (r_b == '0);
   assign w_ovf      = r_sa & r_sb & (r_a == SIGNED_MIN) & (r_b == DIV_ZERO_Q);

   m_abs_neg #(.WIDTH(XLEN)) u_abs_a (.i_neg(w_sign_a), .i_val(r_a), .o_val(w_abs_a));
   m_abs_neg #(.WIDTH(XLEN)) u_abs_b (.i_neg(w_sign_b), .i_val(r_b), .o_val(w_abs_b));
   m_abs_neg #(.WIDTH(2*XLEN)) u_fix (.i_neg(r_neg), .i_val(w_fix_in), .o_val(w_fix_out));

   // One iteration step: shift-add for multiply, restoring subtract for divide.
   // The accumulator low half holds multiplier/quotient bits, high half the
   // partial product/remainder.
   always_comb begin
      w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
      w_mul_next  = {w_mul_sum, r_acc[XLEN-1:1]};
      w_div_trial = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_mcand};
      w_div_next  = w_div_trial[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                      : {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
   end

   // Sign fixup, word selection and special-case overrides for the result.
   always_comb begin
      w_fix_in = r_mult ? r_acc
                        : {{XLEN{1'b0}}, (r_upper ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0])};
      w_sel    = (r_mult & r_upper) ? w_fix_out[2*XLEN-1:XLEN] : w_fix_out[XLEN-1:0];
      w_result = w_sel;
      if (!r_mult && w_div_zero) begin
         w_result = r_upper ? r_a : DIV_ZERO_Q;
      end else if (!r_mult && w_ovf) begin
         w_result = r_upper ? '0 : SIGNED_MIN;
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // Next-state logic; a kill in any busy state returns to IDLE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:  if (w_accept) w_next = PREP;
`ifdef M_EXEC_FAST_SPECIAL_EN
         PREP:  w_next = (!r_mult && (w_div_zero || w_ovf)) ? FIXUP : CALC;
`else
         PREP:  w_next = CALC;
`endif
         CALC:  if (r_cnt == c_cnt_last) w_next = FIXUP;
         FIXUP: w_next = DONE;
         DONE:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (bus.kill_i && (r_state != IDLE)) w_next = IDLE;
   end

   // Datapath registers: capture on accept, prepare magnitudes, iterate, load result.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cnt    <= '0;
         r_mult   <= 1'b0;
         r_sa     <= 1'b0;
         r_sb     <= 1'b0;
         r_upper  <= 1'b0;
         r_neg    <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_mcand  <= '0;
         r_acc    <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_accept) begin
               r_mult  <= bus.mult_on_i;   // multiply wins when both are set
               r_sa    <= bus.signed_A_i;
               r_sb    <= bus.signed_B_i;
               r_upper <= bus.upper_rem_i;
               r_a     <= bus.op_a_i;
               r_b     <= bus.op_b_i;
            end
            PREP: begin
               r_acc   <= {{XLEN{1'b0}}, w_abs_a};
               r_mcand <= w_abs_b;
               r_cnt   <= '0;
               r_neg   <= (!r_mult && r_upper) ? w_sign_a : (w_sign_a ^ w_sign_b);
            end
            CALC: begin
               r_acc <= r_mult ? w_mul_next : w_div_next;
               r_cnt <= r_cnt + CNT_W'(1);
            end
            FIXUP: if (!bus.kill_i) r_result <= w_result;
            default: ;
         endcase
      end
   end

   assign bus.busy_o   = (r_state != IDLE);
   assign bus.done_o   = (r_state == DONE) & ~bus.kill_i;
   assign bus.result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_m_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_m_exec_unit
//  Purpose  : Directed self-checking bench for m_exec_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_m_exec_unit;
   import m_exec_pkg::*;

`ifdef M_EXEC_FAST_SPECIAL_EN
   localparam int SPECIAL_LAT = 3;
`else
   localparam int SPECIAL_LAT = 35;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   m_exec_if #(.XLEN(32)) bus ();
   m_exec_unit #(.XLEN(32)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic m, input logic d, input logic sa, input logic sb,
                         input logic up, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.start_i = 1'b1; bus.mult_on_i = m; bus.div_on_i = d;
      bus.signed_A_i = sa; bus.signed_B_i = sb; bus.upper_rem_i = up;
      bus.op_a_i = a; bus.op_b_i = b;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
   endtask

   // Cycle c_in is the cycle currently being observed (1 = first after accept).
   task automatic wait_done(input int c_in, output int lat, output int nbusy);
      int c = c_in;
      lat = 0; nbusy = 0;
      while (c <= 60) begin
         if (!bus.busy_o) nbusy++;
         if (bus.done_o) begin lat = c; break; end
         @(posedge clk); #1; c++;
      end
   endtask

   task automatic run(input string tag, input logic m, input logic d, input logic sa,
                      input logic sb, input logic up, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat, nb;
      launch(m, d, sa, sb, up, a, b);
      wait_done(1, lat, nb);
      check({tag, "_res"}, bus.result_o, exp);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      @(posedge clk); #1;
      check({tag, "_idle"}, {30'd0, bus.busy_o, bus.done_o}, 32'd0);
   endtask

   initial begin
      int lat, nb, dcnt;
      logic [31:0] held;
      bus.start_i = 0; bus.mult_on_i = 0; bus.div_on_i = 0; bus.signed_A_i = 0;
      bus.signed_B_i = 0; bus.upper_rem_i = 0; bus.op_a_i = 0; bus.op_b_i = 0;
      bus.kill_i = 0;

      // Reset state
      #22;
      check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
      check("rst_done", {31'd0, bus.done_o}, 32'd0);
      check("rst_result", bus.result_o, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // MUL with full latency and busy profile
      launch(1, 0, 0, 0, 0, 32'd7, 32'hFFFFFFFD);
      wait_done(1, lat, nb);
      check("mul_res", bus.result_o, 32'hFFFFFFEB);
      check("mul_lat", 32'(lat), 32'd35);
      check("mul_busy_gaps", 32'(nb), 32'd0);
      @(posedge clk); #1;
      check("mul_after", {30'd0, bus.busy_o, bus.done_o}, 32'd0);

      run("mulh",   1, 0, 1, 1, 1, 32'h80000000, 32'h80000000, 32'h40000000, 35);
      run("mulhu",  1, 0, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35);
      run("mulhsu", 1, 0, 1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 35);
      run("both_en", 1, 1, 0, 0, 0, 32'd100, 32'd7, 32'd700, 35);
      run("div",    0, 1, 1, 1, 0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 35);
      run("rem",    0, 1, 1, 1, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 35);
      run("divu",   0, 1, 0, 0, 0, 32'd100, 32'd7, 32'd14, 35);
      run("remu",   0, 1, 0, 0, 1, 32'd100, 32'd7, 32'd2, 35);
      run("divu_z", 0, 1, 0, 0, 0, 32'd5, 32'd0, 32'hFFFFFFFF, SPECIAL_LAT);
      run("rem_z",  0, 1, 1, 1, 1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, SPECIAL_LAT);
      run("div_ov", 0, 1, 1, 1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPECIAL_LAT);
      run("rem_ov", 0, 1, 1, 1, 1, 32'h80000000, 32'hFFFFFFFF, 32'd0, SPECIAL_LAT);
      run("remu_z", 0, 1, 0, 0, 1, 32'd5, 32'd0, 32'd5, SPECIAL_LAT);

      // Start with both enables low is ignored
      launch(0, 0, 0, 0, 0, 32'd9, 32'd9);
      check("noop_start", {31'd0, bus.busy_o}, 32'd0);

      // Kill during cycle 10 of a DIV
      held = 32'd5;
      launch(0, 1, 1, 1, 0, 32'd100, 32'd7);
      for (int c = 1; c < 10; c++) begin @(posedge clk); #1; end
      bus.kill_i = 1'b1;
      @(posedge clk); #1;
      bus.kill_i = 1'b0;
      check("kill_busy", {31'd0, bus.busy_o}, 32'd0);
      dcnt = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus.done_o) dcnt++;
         @(posedge clk); #1;
      end
      check("kill_no_done", 32'(dcnt), 32'd0);
      check("kill_result", bus.result_o, held);
      run("post_kill", 0, 1, 1, 1, 0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 35);

      // Start pulsed while busy is ignored
      launch(0, 1, 0, 0, 0, 32'd100, 32'd7);
      for (int c = 1; c < 5; c++) begin @(posedge clk); #1; end
      bus.start_i = 1'b1; bus.mult_on_i = 1'b1; bus.div_on_i = 1'b0;
      bus.op_a_i = 32'd3; bus.op_b_i = 32'd3;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      wait_done(6, lat, nb);
      check("busy_start_res", bus.result_o, 32'd14);
      check("busy_start_lat", 32'(lat), 32'd35);
      @(posedge clk); #1;

      // Async reset mid-CALC
      launch(1, 0, 0, 0, 0, 32'd7, 32'd3);
      for (int c = 1; c < 10; c++) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      check("arst_busy", {31'd0, bus.busy_o}, 32'd0);
      check("arst_done", {31'd0, bus.done_o}, 32'd0);
      check("arst_result", bus.result_o, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      dcnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (bus.done_o || bus.busy_o) dcnt++;
      end
      check("arst_quiet", 32'(dcnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
